// File: rtl/gen_trafico_qos_pkg.sv
// gen_trafico_qos_pkg: FSM state encoding, default parameters and LFSR tap table for the traffic generator
package gen_trafico_qos_pkg;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_SEND, S_DRAIN, S_DONE} state_t;

    localparam int DEF_BW      = 6;
    localparam int DEF_N_DEST  = 2;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 256;

    // Galois right-shift feedback masks giving maximal-length sequences for widths 2..16
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

endpackage

// File: rtl/gen_trafico_qos_lfsr_gen.sv
// lfsr_gen: maximal-length Galois LFSR payload source, seeded to 1 on load, advanced on step
//  clk, reset  clock / synchronous active-high reset
//  load        reseed to 1
//  step        advance one state
//  q           current LFSR value (width W, 2..16)
module lfsr_gen
    import gen_trafico_qos_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    always_ff @(posedge clk) begin
        if (reset || load)
            q <= W'(1);
        else if (step)
            q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end

endmodule

// File: rtl/gen_trafico_qos.sv
// gen_trafico_qos: traffic generator/checker for the Main->Dn FIFO path (payload from LFSR when GEN_LFSR_EN is defined, else a counter)
//  clk, reset            clock / synchronous active-high reset
//  start                 run request, accepted in IDLE or DONE
//  cfg_num_words         words to send, latched on accepted start
//  cfg_rd_mask           per-destination read enable, latched on accepted start
//  main_full/wr/data     Main FIFO push interface
//  dst_empty/error/rd    per-destination FIFO status and pops
//  dst_data              per-destination read data, valid the cycle after a pop
//  init/busy/done/pass   status; mismatch/timeout are sticky error flags
module gen_trafico_qos
    import gen_trafico_qos_pkg::*;
#(
    parameter int BW      = DEF_BW,
    parameter int N_DEST  = DEF_N_DEST,
    parameter int DEST_W  = $clog2(N_DEST),
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cfg_num_words,
    input  logic [N_DEST-1:0]    cfg_rd_mask,
    input  logic                 main_full,
    output logic                 main_wr,
    output logic [BW-1:0]        main_data,
    input  logic [N_DEST-1:0]    dst_empty,
    input  logic [N_DEST-1:0]    dst_error,
    output logic [N_DEST-1:0]    dst_rd,
    input  logic [N_DEST*BW-1:0] dst_data,
    output logic                 init,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_DEST-1:0]    mismatch,
    output logic                 timeout
);

    localparam int PW = BW - DEST_W;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  num, sent;
    logic [N_DEST-1:0] mask, rd_q, eq;
    logic [DEST_W-1:0] d_idx;
    logic [PW-1:0]     payload;
    logic [TW-1:0]     tmo;
    logic              acc, push, active, tmo_hit, all_rcvd;
    logic              unused_ok;

    assign unused_ok = ^dst_data;
    assign acc       = start && (state == S_IDLE || state == S_DONE);
    assign push      = state == S_SEND && !main_full && sent < num;
    assign dst_rd    = (state == S_SEND || state == S_DRAIN) ? mask & ~dst_empty & ~dst_error : '0;
    // a pop, a push in flight or a word about to be checked all count as progress
    assign active    = |dst_rd || main_wr || |rd_q;
    assign tmo_hit   = state == S_DRAIN && !active && tmo == TW'(TIMEOUT - 1);
    assign all_rcvd  = &eq;
    assign init      = state == S_INIT;
    assign busy      = state == S_INIT || state == S_SEND || state == S_DRAIN;
    assign done      = state == S_DONE;
    assign pass      = done && !timeout && !(|mismatch) && !(|(dst_error & mask)) && all_rcvd;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = acc ? S_INIT : S_IDLE;
            S_INIT:  state_n = S_SEND;
            S_SEND:  state_n = sent == num ? S_DRAIN : S_SEND;
            S_DRAIN: state_n = (all_rcvd || tmo_hit) ? S_DONE : S_DRAIN;
            S_DONE:  state_n = acc ? S_INIT : S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            num       <= '0;
            mask      <= '0;
            sent      <= '0;
            d_idx     <= '0;
            main_wr   <= 1'b0;
            main_data <= '0;
            rd_q      <= '0;
            tmo       <= '0;
            timeout   <= 1'b0;
        end else begin
            state   <= state_n;
            main_wr <= push;
            rd_q    <= dst_rd;
            tmo     <= (state != S_DRAIN || active) ? '0 : tmo + TW'(1);
            if (acc) begin
                num  <= cfg_num_words;
                mask <= cfg_rd_mask;
            end
            if (state == S_INIT) begin
                sent    <= '0;
                d_idx   <= '0;
                timeout <= 1'b0;
            end else begin
                if (tmo_hit)
                    timeout <= 1'b1;
                if (push) begin
                    sent      <= sent + CNT_W'(1);
                    d_idx     <= d_idx == DEST_W'(N_DEST - 1) ? '0 : d_idx + DEST_W'(1);
                    main_data <= {d_idx, payload};
                end
            end
        end
    end

`ifdef GEN_LFSR_EN
    lfsr_gen #(.W(PW)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (state == S_INIT),
        .step  (push),
        .q     (payload)
    );
`else
    always_ff @(posedge clk)
        payload <= (reset || state == S_INIT) ? '0 : payload + PW'(push);
`endif

    for (genvar i = 0; i < N_DEST; i++) begin : g_dst
        logic [CNT_W-1:0] sent_c, rcvd_c;
        logic             mm;
        always_ff @(posedge clk) begin
            if (reset || state == S_INIT) begin
                sent_c <= '0;
                rcvd_c <= '0;
                mm     <= 1'b0;
            end else begin
                if (push && d_idx == DEST_W'(i))
                    sent_c <= sent_c + CNT_W'(~&sent_c);
                if (rd_q[i]) begin
                    rcvd_c <= rcvd_c + CNT_W'(~&rcvd_c);
                    if (dst_data[i*BW+BW-1 -: DEST_W] != DEST_W'(i))
                        mm <= 1'b1;
                end
            end
        end
        // masked destinations never hold up completion
        assign eq[i]       = ~mask[i] | (rcvd_c == sent_c);
        assign mismatch[i] = mm;
    end

endmodule
